instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer end of the PC interface: captures each PC produced by the PC block, reads the
//  word from a handshaked instruction memory, and returns the fields that feed back into
//  PC and decode (Instr, Opcode, Instr25_0, Instr15_0).
//  Handles variable memory latency and flush on taken branch/jump.
//  Holds the last fetched word, so decode sees a stable instruction while a fetch is pending.
// PARAMETERS
//  ADDR_W   32  width of MemAddr; PC[ADDR_W-1:0] is forwarded
//  TIMEOUT  16  cycles in WAIT without MemRValid before retry; 1..255
// PORTS
//  Clk        in   1   single clock, all state on posedge
//  Rst_n      in   1   asynchronous, active-low reset
//  PC         in   32  fetch address from PC block
//  PCValid    in   1   PC holds a new address to fetch
//  Redirect   in   1   Jump | (PCSrc taken); in-flight fetch is stale
//  Stall      in   1   decode not ready; hold current instruction
//  MemReq     out  1   read request to instruction memory
//  MemAddr    out  ADDR_W  word-aligned read address
//  MemGnt     in   1   memory accepted request this cycle
//  MemRData   in   32  read data
//  MemRValid  in   1   MemRData valid this cycle
//  Instr      out  32  held instruction word
//  Opcode     out  6   Instr[31:26]
//  Instr25_0  out  26  jump target field
//  Instr15_0  out  16  immediate field
//  InstrValid out  1   Instr is a completed, non-stale fetch
//  FetchBusy  out  1   state is ISSUE, WAIT or DROP
//  MisalignErr out 1   one-cycle pulse: PC[1:0] != 0 was presented
//  MemTimeout out  1   one-cycle pulse: TIMEOUT expired in WAIT
// BEHAVIOUR
//  Reset values:
//   - FSM = IDLE; every output 0; Instr = 32'h0000_0000.
//   - Captured-PC register and timeout counter = 0.
//  FSM states IDLE, ISSUE, WAIT, HOLD, DROP.
//  IDLE / HOLD:
//   - PCValid & !Stall captures PC.
//   - PC[1:0] != 0: pulse MisalignErr, clear InstrValid, go to IDLE, issue nothing.
//   - Otherwise clear InstrValid and go to ISSUE.
//   - PCValid & Stall in HOLD: ignored; the PC block must re-present it.
//  ISSUE:
//   - MemReq = 1 and MemAddr = captured PC until MemGnt.
//   - MemGnt -> WAIT and clear timeout counter.
//   - Redirect with no MemGnt -> IDLE (nothing outstanding).
//   - Redirect with MemGnt -> DROP.
//  WAIT:
//   - Counter increments each cycle.
//   - MemRValid & !Redirect: Instr <= MemRData, InstrValid = 1 next cycle, go to HOLD.
//   - MemRValid & Redirect: discard data, go to IDLE.
//   - Redirect alone: go to DROP.
//   - Counter == TIMEOUT-1: pulse MemTimeout, go to ISSUE (retry same PC).
//   - A late response after a timeout is accepted as the retry's data.
//  DROP:
//   - Waits for MemRValid, discards data, then goes to IDLE. No timeout in DROP.
//   - PCValid here is captured and served after DROP; the newest address wins.
//  Redirect in IDLE or HOLD: clears InstrValid only.
//  Latency: request raised 1 cycle after PCValid capture.
//   InstrValid rises 1 cycle after MemRValid.
//   Minimum PCValid -> InstrValid is 3 cycles (MemGnt on first ISSUE cycle, 1-cycle memory).
//  Field outputs are combinational slices of the registered Instr; they never change while
//   InstrValid & Stall.
//  At most one outstanding memory request. MemReq never rises in WAIT or DROP.
//  Rst_n low at any time forces IDLE immediately. Any outstanding response after reset is
//   ignored, because MemRValid outside WAIT/DROP has no effect.
// STRUCTURE
//  Shared package mips_pkg:
//   - FSM state encoding (3-bit localparams).
//   - OPCODE_LSB = 26 and IMM_W = 16.
//   - INSTR_W = 32.
//  One sub-module: fetch_timeout_ctr (8-bit counter: clear, enable, expire = count==TIMEOUT-1).
//  All other logic lives in instr_fetch_unit.
// TESTING
//  1. Rst_n released; PC=0x0000_0040, PCValid=1; MemGnt same cycle; MemRValid next cycle with
//     0x0810_0004 -> InstrValid=1, Opcode=6'h02, Instr25_0=26'h010_0004, Instr15_0=16'h0004.
//  2. PC=0x0000_0042 with PCValid -> MisalignErr pulses 1 cycle; MemReq stays 0; InstrValid=0.
//  3. Fetch 0x100 granted; Redirect in WAIT; data 0xDEAD_BEEF returns 4 cycles later -> DROP
//     discards it, Instr unchanged, InstrValid=0. Next PCValid 0x200 fetches normally.
//  4. TIMEOUT=4; MemGnt given, MemRValid withheld -> MemTimeout pulses after 4 WAIT cycles;
//     MemReq re-asserted with the same MemAddr.
//  5. InstrValid=1 with Stall=1 for 5 cycles while PCValid toggles -> Instr and fields stable,
//     no MemReq. Release Stall -> next PCValid starts a fetch.
//  6. Rst_n pulsed low during WAIT -> all outputs 0 asynchronously; subsequent MemRValid ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: FSM encoding and instruction field geometry.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_W      = 16;

    // 3-bit state encoding, kept as localparams so other blocks can decode a state bus
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_HOLD  = S_HOLD,
        ST_DROP  = S_DROP
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Handshaked instruction-memory read port. The fetch unit is the master.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemGnt;
    logic [31:0]       MemRData;
    logic              MemRValid;

    modport master (
        output MemReq, MemAddr,
        input  MemGnt, MemRData, MemRValid
    );

    modport slave (
        input  MemReq, MemAddr,
        output MemGnt, MemRData, MemRValid
    );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for the WAIT state; expire flags the last allowed cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [7:0] r_cnt;

    // clear has priority so a fresh grant always restarts the window
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)      r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_en)   r_cnt <= r_cnt + 8'd1;
    end

    assign o_expire = (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: captures a PC, performs one handshaked memory read at a
// time, and holds the returned word for decode. Redirects make the in-flight
// read stale; its response is drained in DROP so it never reaches decode.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [31:0]          PC,
    input  logic                 PCValid,
    input  logic                 Redirect,
    input  logic                 Stall,
    instr_fetch_unit_if.master   mem,
    output logic [INSTR_W-1:0]   Instr,
    output logic [5:0]           Opcode,
    output logic [25:0]          Instr25_0,
    output logic [IMM_W-1:0]     Instr15_0,
    output logic                 InstrValid,
    output logic                 FetchBusy,
    output logic                 MisalignErr,
    output logic                 MemTimeout
);
    fetch_state_e        r_state, w_next;
    logic [ADDR_W-1:2]   r_pc;
    logic                r_pend;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_ivalid, r_mis, r_tmo;

    logic w_pc_mis, w_cap, w_mis, w_load, w_clr_iv, w_tmo, w_pend, w_expire;

    assign w_pc_mis = |PC[1:0];
    // in DROP the newest presented address decides whether a fetch follows
    assign w_pend   = PCValid ? !w_pc_mis : r_pend;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_clr    (r_state == ST_ISSUE && mem.MemGnt),
        .i_en     (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    // next state and per-cycle actions
    always_comb begin
        w_next   = r_state;
        w_cap    = 1'b0;
        w_mis    = 1'b0;
        w_load   = 1'b0;
        w_clr_iv = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (PCValid && !Stall) begin
                    w_clr_iv = 1'b1;
                    if (w_pc_mis) begin
                        w_mis  = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_cap  = 1'b1;
                        w_next = ST_ISSUE;
                    end
                end else if (Redirect) begin
                    w_clr_iv = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem.MemGnt)    w_next = Redirect ? ST_DROP : ST_WAIT;
                else if (Redirect) w_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (mem.MemRValid) begin
                    w_load = !Redirect;
                    w_next = Redirect ? ST_IDLE : ST_HOLD;
                end else if (Redirect) begin
                    w_next = ST_DROP;
                end else if (w_expire) begin
                    w_tmo  = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (PCValid) begin
                    w_mis = w_pc_mis;
                    w_cap = !w_pc_mis;
                end
                if (mem.MemRValid) w_next = w_pend ? ST_ISSUE : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // captured fetch address and the pending-after-drop flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc   <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_cap) r_pc <= PC[ADDR_W-1:2];
            r_pend <= (r_state == ST_DROP && w_next == ST_DROP) ? w_pend : 1'b0;
        end
    end

    // held instruction word and its valid flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_instr  <= '0;
            r_ivalid <= 1'b0;
        end else begin
            if (w_load) r_instr <= mem.MemRData;
            if (w_load)        r_ivalid <= 1'b1;
            else if (w_clr_iv) r_ivalid <= 1'b0;
        end
    end

    // single-cycle error pulses
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mis <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            r_mis <= w_mis;
            r_tmo <= w_tmo;
        end
    end

    assign mem.MemReq  = (r_state == ST_ISSUE);
    assign mem.MemAddr = {r_pc, 2'b00};

    assign Instr       = r_instr;
    assign Opcode      = r_instr[INSTR_W-1:OPCODE_LSB];
    assign Instr25_0   = r_instr[OPCODE_LSB-1:0];
    assign Instr15_0   = r_instr[IMM_W-1:0];
    assign InstrValid  = r_ivalid;
    assign FetchBusy   = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_DROP);
    assign MisalignErr = r_mis;
    assign MemTimeout  = r_tmo;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios followed by a randomized run scored against a
// transaction-level model of the fetch unit.
module tb_instr_fetch_unit;
    localparam int TMO = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] PC = '0;
    logic        PCValid = 1'b0, Redirect = 1'b0, Stall = 1'b0;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [25:0] Instr25_0;
    logic [15:0] Instr15_0;
    logic        InstrValid, FetchBusy, MisalignErr, MemTimeout;

    int n_chk = 0;
    int n_pass = 0;

    instr_fetch_unit_if #(.ADDR_W(32)) mem_if ();

    instr_fetch_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PC(PC), .PCValid(PCValid), .Redirect(Redirect),
        .Stall(Stall), .mem(mem_if), .Instr(Instr), .Opcode(Opcode),
        .Instr25_0(Instr25_0), .Instr15_0(Instr15_0), .InstrValid(InstrValid),
        .FetchBusy(FetchBusy), .MisalignErr(MisalignErr), .MemTimeout(MemTimeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // PCValid -> grant on first ISSUE cycle -> 1-cycle memory
    task automatic fetch_ok(input string tag, input logic [31:0] pc, input logic [31:0] data);
        PC = pc; PCValid = 1'b1; tick(); PCValid = 1'b0;
        check({tag, "_req"}, mem_if.MemReq, 1);
        check({tag, "_addr"}, mem_if.MemAddr, pc);
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        check({tag, "_waitreq"}, mem_if.MemReq, 0);
        mem_if.MemRValid = 1'b1; mem_if.MemRData = data; tick(); mem_if.MemRValid = 1'b0;
        check({tag, "_iv"}, InstrValid, 1);
        check({tag, "_instr"}, Instr, data);
    endtask

    initial begin
        bit busy, killed, outst, exp_iv, exp_mis;
        logic [31:0] f_pc, exp_instr, out_addr, pcv;
        int lat;

        mem_if.MemGnt = 1'b0; mem_if.MemRValid = 1'b0; mem_if.MemRData = '0;
        @(negedge Clk); @(negedge Clk);
        check("rst_instr", Instr, 0);
        check("rst_iv", InstrValid, 0);
        check("rst_busy", FetchBusy, 0);
        check("rst_req", mem_if.MemReq, 0);
        check("rst_addr", mem_if.MemAddr, 0);
        check("rst_errs", {MisalignErr, MemTimeout}, 0);
        Rst_n = 1'b1; tick();

        // 1: basic fetch and field slicing
        fetch_ok("t1", 32'h40, 32'h0810_0004);
        check("t1_op", Opcode, 6'h02);
        check("t1_j", Instr25_0, 26'h010_0004);
        check("t1_imm", Instr15_0, 16'h0004);

        // 2: misaligned PC
        PC = 32'h42; PCValid = 1'b1; tick(); PCValid = 1'b0;
        check("t2_mis", MisalignErr, 1);
        check("t2_req", mem_if.MemReq, 0);
        check("t2_iv", InstrValid, 0);
        tick();
        check("t2_mis_pulse", MisalignErr, 0);
        check("t2_req2", mem_if.MemReq, 0);

        // 3: redirect in WAIT, stale data drained in DROP
        PC = 32'h100; PCValid = 1'b1; tick(); PCValid = 1'b0;
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        Redirect = 1'b1; tick(); Redirect = 1'b0;
        check("t3_busy", FetchBusy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_dropreq", mem_if.MemReq, 0);
            check("t3_droptmo", MemTimeout, 0);
        end
        mem_if.MemRValid = 1'b1; mem_if.MemRData = 32'hDEAD_BEEF; tick(); mem_if.MemRValid = 1'b0;
        check("t3_idle", FetchBusy, 0);
        check("t3_iv", InstrValid, 0);
        check("t3_instr", Instr, 32'h0810_0004);
        fetch_ok("t3b", 32'h200, 32'h8C42_0010);

        // 3c: addresses presented during DROP, newest served afterwards
        PC = 32'h600; PCValid = 1'b1; tick(); PCValid = 1'b0;
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        Redirect = 1'b1; tick(); Redirect = 1'b0;
        PC = 32'h604; PCValid = 1'b1; tick();
        PC = 32'h608; tick(); PCValid = 1'b0;
        mem_if.MemRValid = 1'b1; mem_if.MemRData = 32'h1111_1111; tick(); mem_if.MemRValid = 1'b0;
        check("t3c_req", mem_if.MemReq, 1);
        check("t3c_addr", mem_if.MemAddr, 32'h608);
        check("t3c_iv", InstrValid, 0);
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        mem_if.MemRValid = 1'b1; mem_if.MemRData = 32'h2222_0608; tick(); mem_if.MemRValid = 1'b0;
        check("t3c_instr", Instr, 32'h2222_0608);

        // 4: timeout after TMO WAIT cycles, retry same address, late data accepted
        PC = 32'h300; PCValid = 1'b1; tick(); PCValid = 1'b0;
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("t4_notmo", MemTimeout, 0);
            check("t4_noreq", mem_if.MemReq, 0);
        end
        tick();
        check("t4_tmo", MemTimeout, 1);
        check("t4_retry", mem_if.MemReq, 1);
        check("t4_addr", mem_if.MemAddr, 32'h300);
        tick();
        check("t4_tmo_pulse", MemTimeout, 0);
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        mem_if.MemRValid = 1'b1; mem_if.MemRData = 32'h3C01_1234; tick(); mem_if.MemRValid = 1'b0;
        check("t4_iv", InstrValid, 1);
        check("t4_instr", Instr, 32'h3C01_1234);

        // 5: stall holds the instruction while PCValid toggles
        Stall = 1'b1; PC = 32'h400;
        for (int i = 0; i < 5; i++) begin
            PCValid = (i % 2 == 0);
            tick();
            check("t5_instr", Instr, 32'h3C01_1234);
            check("t5_op", Opcode, 6'h0F);
            check("t5_req", mem_if.MemReq, 0);
            check("t5_iv", InstrValid, 1);
        end
        Stall = 1'b0; PCValid = 1'b0;
        fetch_ok("t5b", 32'h400, 32'hAC85_0008);

        // 6: asynchronous reset during WAIT, response afterwards ignored
        PC = 32'h500; PCValid = 1'b1; tick(); PCValid = 1'b0;
        mem_if.MemGnt = 1'b1; tick(); mem_if.MemGnt = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        check("t6_busy", FetchBusy, 0);
        check("t6_iv", InstrValid, 0);
        check("t6_instr", Instr, 0);
        check("t6_req", mem_if.MemReq, 0);
        tick(); Rst_n = 1'b1;
        mem_if.MemRValid = 1'b1; mem_if.MemRData = 32'hFFFF_FFFF; tick(); mem_if.MemRValid = 1'b0;
        check("t6_late_iv", InstrValid, 0);
        check("t6_late_instr", Instr, 0);
        check("t6_late_busy", FetchBusy, 0);

        // randomized traffic against a transaction-level model
        busy = 0; killed = 0; outst = 0; exp_iv = 0; exp_mis = 0;
        f_pc = '0; exp_instr = '0; out_addr = '0; lat = 0;
        for (int c = 0; c < 600; c++) begin
            check("r_busy", FetchBusy, busy);
            check("r_iv", InstrValid, exp_iv);
            check("r_mis", MisalignErr, exp_mis);
            check("r_tmo", MemTimeout, 0);
            check("r_1out", mem_if.MemReq & outst, 0);
            if (exp_iv) begin
                check("r_instr", Instr, exp_instr);
                check("r_imm", Instr15_0, exp_instr[15:0]);
            end

            PCValid = 1'b0; Redirect = 1'b0; Stall = ($urandom_range(0, 3) == 0);
            mem_if.MemGnt = 1'b0; mem_if.MemRValid = 1'b0; exp_mis = 0;
            if (outst) begin
                if (lat == 0) begin
                    mem_if.MemRValid = 1'b1; mem_if.MemRData = memf(out_addr); outst = 0;
                end else lat--;
            end else if (mem_if.MemReq && $urandom_range(0, 1) == 1) begin
                check("r_addr", mem_if.MemAddr, f_pc);
                mem_if.MemGnt = 1'b1; outst = 1; out_addr = mem_if.MemAddr;
                lat = $urandom_range(0, 2);
            end
            if (!FetchBusy && $urandom_range(0, 2) == 0) begin
                pcv = $urandom_range(0, 1023) << 2;
                if ($urandom_range(0, 7) == 0) pcv = pcv | $urandom_range(1, 3);
                PC = pcv; PCValid = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                Redirect = 1'b1;
            end

            if (PCValid && !Stall) begin
                exp_iv = 0;
                if (PC[1:0] != 2'b00) exp_mis = 1;
                else begin busy = 1; killed = 0; f_pc = PC; end
            end else if (busy) begin
                if (Redirect) killed = 1;
                if (mem_if.MemRValid) begin
                    busy = 0;
                    if (!killed) begin exp_iv = 1; exp_instr = memf(f_pc); end
                end else if (Redirect && mem_if.MemReq && !mem_if.MemGnt) begin
                    busy = 0;
                end
            end else if (Redirect) begin
                exp_iv = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
